exe_div_unit: RTL and testbench
===============================

# exe_div_unit

Parametrised iterative integer divide/remainder unit for the EXE stage. It implements RISC-V DIV, DIVU, REM and REMU for a configurable operand width and radix. It accepts one operation at a time, produces a tagged result held until EXE consumes it, and supports pipeline kill on flush/exception. It reproduces RISC-V divide-by-zero and signed-overflow results, with an optional early-out path for those cases.

## Interface
Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and a multiple of BITS_PER_CYCLE
- BITS_PER_CYCLE, 1, quotient bits retired per ITER cycle; legal values 1, 2, 4
- EARLY_OUT, 1, when 1, divide-by-zero and signed overflow complete from PREP without iterating

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- START_SE  in  1  operation request; accepted only when state is IDLE, or DONE with POP_DIV high
- OP1_SE  in  XLEN  dividend, sampled on accepted START
- OP2_SE  in  XLEN  divisor, sampled on accepted START
- CMD_RD  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled on accepted START
- DEST_RD  in  6  destination register tag, sampled on accepted START
- KILL_SE  in  1  abort current operation (flush)
- POP_DIV  in  1  EXE consumes result; meaningful only while DONE_DIV is high
- BUSY_DIV  out  1  high in every state except IDLE
- DONE_DIV  out  1  high exactly while state is DONE
- RES_DIV  out  XLEN  quotient or remainder; valid while DONE_DIV is high, else 0
- DEST_DIV  out  6  latched tag; valid while DONE_DIV is high, else 0

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE -> PREP on START_SE:
  - latch operands, CMD and DEST;
  - for signed ops (DIV/REM), record sign of quotient (OP1 sign XOR OP2 sign) and sign of remainder (OP1 sign).
- PREP:
  - compute absolute values for signed ops; unsigned ops pass through;
  - clear partial remainder; load iteration counter with XLEN/BITS_PER_CYCLE;
  - if EARLY_OUT=1 and a special case is detected, load result and go to DONE; otherwise go to ITER.
- ITER:
  - restoring division, BITS_PER_CYCLE shift/compare-subtract steps per cycle, chained combinationally;
  - counter decrements each cycle; at 0 -> FIXUP.
- FIXUP:
  - negate quotient/remainder per recorded signs;
  - select quotient (DIV/DIVU) or remainder (REM/REMU) into result register;
  - -> DONE.
- DONE: hold result and tag.
  - POP_DIV without START -> IDLE.
  - POP_DIV with START -> PREP with the new operands (back-to-back).
  - No POP_DIV -> stay in DONE indefinitely; START ignored.
- Special cases (RISC-V), identical results with EARLY_OUT=0 or 1:
  - divisor 0: quotient all ones (DIV and DIVU); remainder = dividend.
  - signed overflow (OP1 = most-negative, OP2 = all ones, DIV/REM only): quotient = OP1, remainder = 0.
- KILL_SE:
  - in any non-IDLE state -> IDLE at next edge; result discarded; DONE_DIV never asserts for that operation.
  - KILL_SE and START_SE in the same cycle: KILL wins, START is dropped.
  - KILL_SE in IDLE: no effect.
- START_SE in PREP/ITER/FIXUP is ignored; operands already latched are unaffected by input changes.
- Width rules:
  - partial remainder is XLEN+1 bits internally;
  - absolute value of the most-negative operand is treated as unsigned XLEN bits (no overflow);
  - all negation is two's complement modulo 2^XLEN.

## Timing
- Reset (asynchronous, effective immediately): state IDLE; BUSY_DIV=0, DONE_DIV=0, RES_DIV=0, DEST_DIV=0; internal registers cleared.
- Let N = XLEN/BITS_PER_CYCLE. With START_SE accepted in cycle t:
  - PREP in t+1;
  - ITER in t+2 .. t+N+1;
  - FIXUP in t+N+2;
  - DONE_DIV high from t+N+3.
- Early-out special case: DONE_DIV high from t+2.
- Default parameters give a latency of t+35; BITS_PER_CYCLE=4 gives t+11.
- BUSY_DIV rises in t+1; falls the cycle after POP_DIV (no restart) or after KILL_SE.
- Back-to-back: POP_DIV+START_SE in DONE cycle d puts PREP in d+1; no idle bubble.
- Reset asserted mid-operation aborts the operation exactly as KILL does, and additionally clears the outputs.

## Test plan
- DIV -7/2 (0xFFFFFFF9, 0x2), default params -> RES_DIV=0xFFFFFFFD at t+35, DEST echoed. REM with the same operands -> 0xFFFFFFFF.
- DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; REMU -> 0x0000000F. Changing OP1_SE/OP2_SE during ITER does not alter either result.
- DIV 5/0 -> 0xFFFFFFFF at t+2 (EARLY_OUT=1) and at t+35 (EARLY_OUT=0). REMU 5/0 -> 0x5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0x0. REM -8/3 -> 0xFFFFFFFE (remainder takes dividend sign).
- KILL_SE at t+10 -> IDLE and BUSY_DIV=0 at t+11, DONE_DIV never asserts. New START at t+11 completes normally. KILL+START in the same cycle -> START dropped.
- BITS_PER_CYCLE=4: 100/7 -> 14 at t+11. Withhold POP_DIV for 5 cycles -> result stable and START ignored. Then POP+START with 9/3 -> PREP next cycle, result 3 eleven cycles later. Async reset pulse mid-ITER -> all outputs 0 immediately.

Source files
------------

// File: rtl/exe_div_unit.sv
// Iterative restoring divide/remainder unit (RISC-V DIV/DIVU/REM/REMU) for the EXE stage.
// Retires BITS_PER_CYCLE quotient bits per cycle; result and tag held until popped.
module exe_div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_OUT      = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            START_SE,
  input  logic [XLEN-1:0] OP1_SE,
  input  logic [XLEN-1:0] OP2_SE,
  input  logic [1:0]      CMD_RD,
  input  logic [5:0]      DEST_RD,
  input  logic            KILL_SE,
  input  logic            POP_DIV,
  output logic            BUSY_DIV,
  output logic            DONE_DIV,
  output logic [XLEN-1:0] RES_DIV,
  output logic [5:0]      DEST_DIV
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] op1_q, op2_q, quo_q, dvs_q, res_q;
  logic [XLEN:0]   prem_q;
  logic [1:0]      cmd_q;
  logic [5:0]      dest_q;
  logic            q_neg, r_neg;
  logic [CW-1:0]   cnt_q, cnt_nxt;

  logic            accept, div0, ovf, special;
  logic [XLEN-1:0] special_res, quo_nxt;
  logic [XLEN:0]   prem_nxt;

  assign accept = START_SE && !KILL_SE && (state == IDLE || (state == DONE && POP_DIV));

  // Special results are taken from the latched raw operands, so they are
  // identical whether or not the early-out path is enabled.
  always_comb begin
    div0    = (op2_q == '0);
    ovf     = !cmd_q[0] && (op1_q == MIN_NEG) && (op2_q == '1);
    special = div0 || ovf;
    if (div0) special_res = cmd_q[1] ? op1_q : '1;
    else      special_res = cmd_q[1] ? '0 : op1_q;
  end

  always_comb begin
    prem_nxt = prem_q;
    quo_nxt  = quo_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      prem_nxt = {prem_nxt[XLEN-1:0], quo_nxt[XLEN-1]};
      quo_nxt  = {quo_nxt[XLEN-2:0], 1'b0};
      if (prem_nxt >= {1'b0, dvs_q}) begin
        prem_nxt   = prem_nxt - {1'b0, dvs_q};
        quo_nxt[0] = 1'b1;
      end
    end
    cnt_nxt = cnt_q - 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (KILL_SE && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = PREP;
        PREP:    state_nxt = (EARLY_OUT != 0 && special) ? DONE : ITER;
        ITER:    if (cnt_nxt == '0) state_nxt = FIXUP;
        FIXUP:   state_nxt = DONE;
        DONE:    if (accept) state_nxt = PREP;
                 else if (POP_DIV) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op1_q  <= '0;
      op2_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      prem_q <= '0;
      cmd_q  <= '0;
      dest_q <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op1_q  <= OP1_SE;
        op2_q  <= OP2_SE;
        cmd_q  <= CMD_RD;
        dest_q <= DEST_RD;
        q_neg  <= !CMD_RD[0] && (OP1_SE[XLEN-1] ^ OP2_SE[XLEN-1]);
        r_neg  <= !CMD_RD[0] && OP1_SE[XLEN-1];
      end
      case (state)
        PREP: begin
          quo_q  <= (!cmd_q[0] && op1_q[XLEN-1]) ? -op1_q : op1_q;
          dvs_q  <= (!cmd_q[0] && op2_q[XLEN-1]) ? -op2_q : op2_q;
          prem_q <= '0;
          cnt_q  <= CW'(N);
          if (EARLY_OUT != 0 && special) res_q <= special_res;
        end
        ITER: begin
          quo_q  <= quo_nxt;
          prem_q <= prem_nxt;
          cnt_q  <= cnt_nxt;
        end
        FIXUP: begin
          if (special)       res_q <= special_res;
          else if (cmd_q[1]) res_q <= r_neg ? -prem_q[XLEN-1:0] : prem_q[XLEN-1:0];
          else               res_q <= q_neg ? -quo_q : quo_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    BUSY_DIV = (state != IDLE);
    DONE_DIV = (state == DONE);
    RES_DIV  = DONE_DIV ? res_q : '0;
    DEST_DIV = DONE_DIV ? dest_q : '0;
  end

endmodule

// File: tb/tb_exe_div_unit.sv
// Bench for exe_div_unit: three configurations checked every cycle against a
// latency/arithmetic model, plus directed literal cases.
module tb_exe_div_unit;
  localparam int XLEN = 32;
  localparam int BPC_P [3] = '{1, 1, 4};
  localparam int EO_P  [3] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        start[3], kill[3], pop[3];
  logic [31:0] op1[3], op2[3];
  logic [1:0]  cmd[3];
  logic [5:0]  dest[3];
  logic        busy[3], done[3];
  logic [31:0] res[3];
  logic [5:0]  dst[3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    exe_div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC_P[g]), .EARLY_OUT(EO_P[g])) dut (
      .clk(clk), .reset(reset), .START_SE(start[g]), .OP1_SE(op1[g]), .OP2_SE(op2[g]),
      .CMD_RD(cmd[g]), .DEST_RD(dest[g]), .KILL_SE(kill[g]), .POP_DIV(pop[g]),
      .BUSY_DIV(busy[g]), .DONE_DIV(done[g]), .RES_DIV(res[g]), .DEST_DIV(dst[g]));
  end

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] c);
    int signed sa, sb;
    if (b == 32'h0) return c[1] ? a : 32'hFFFF_FFFF;
    if (!c[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'h0 : a;
      sa = a;
      sb = b;
      return c[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return c[1] ? (a % b) : (a / b);
  endfunction

  function automatic int latency(input int k, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] c);
    bit sp;
    sp = (b == 32'h0) || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (EO_P[k] != 0 && sp) return 2;
    return XLEN / BPC_P[k] + 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an accepted op becomes visible after its latency and stays until popped.
  bit          m_busy[3];
  int          m_wait[3];
  logic [31:0] m_res[3];
  logic [5:0]  m_dest[3];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0; m_wait[k] = 0; m_res[k] = '0; m_dest[k] = '0;
      end else begin
        bit mdone;
        mdone = m_busy[k] && m_wait[k] == 0;
        if (m_busy[k] && kill[k]) begin
          m_busy[k] = 1'b0;
        end else if ((!m_busy[k] || (mdone && pop[k])) && start[k] && !kill[k]) begin
          m_busy[k] = 1'b1;
          m_wait[k] = latency(k, op1[k], op2[k], cmd[k]) - 1;
          m_res[k]  = ref_result(op1[k], op2[k], cmd[k]);
          m_dest[k] = dest[k];
        end else if (mdone && pop[k]) begin
          m_busy[k] = 1'b0;
        end else if (m_busy[k] && m_wait[k] > 0) begin
          m_wait[k]--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        bit ed;
        ed = m_busy[k] && m_wait[k] == 0;
        check($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
        check($sformatf("done[%0d]", k), 32'(done[k]), 32'(ed));
        check($sformatf("res[%0d]", k), res[k], ed ? m_res[k] : 32'h0);
        check($sformatf("dest[%0d]", k), 32'(dst[k]), ed ? 32'(m_dest[k]) : 32'h0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Starts in the current cycle t, returns in t+1 with operand inputs scrambled.
  task automatic launch(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic [5:0] d);
    start[k] = 1'b1; op1[k] = a; op2[k] = b; cmd[k] = c; dest[k] = d;
    tick(1);
    start[k] = 1'b0; op1[k] = $urandom; op2[k] = $urandom;
    cmd[k] = 2'($urandom); dest[k] = 6'($urandom);
  endtask

  task automatic wait_done(input int k, input logic [31:0] exp, input int lat,
                           input logic [5:0] d, input string name);
    int j;
    j = 1;
    while (!done[k] && j < 200) begin
      tick(1);
      j++;
    end
    check({name, " latency"}, 32'(j), 32'(lat));
    check({name, " result"}, res[k], exp);
    check({name, " tag"}, 32'(dst[k]), 32'(d));
  endtask

  task automatic pop_it(input int k);
    pop[k] = 1'b1;
    tick(1);
    pop[k] = 1'b0;
  endtask

  int tag = 0;
  task automatic run(input int k, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] c, input logic [31:0] exp, input int lat,
                     input string name);
    tag++;
    launch(k, a, b, c, 6'(tag));
    wait_done(k, exp, lat, 6'(tag), name);
    pop_it(k);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; kill[k] = 1'b0; pop[k] = 1'b0;
      op1[k] = '0; op2[k] = '0; cmd[k] = '0; dest[k] = '0;
    end
    tick(2);
    for (int k = 0; k < 3; k++) begin
      check("reset busy", 32'(busy[k]), 32'h0);
      check("reset res", res[k], 32'h0);
    end
    reset = 1'b0;
    chk_en = 1'b1;
    tick(1);

    run(0, 32'hFFFF_FFF9, 32'h2,         2'b00, 32'hFFFF_FFFD, 35, "div -7/2");
    run(0, 32'hFFFF_FFF9, 32'h2,         2'b10, 32'hFFFF_FFFF, 35, "rem -7/2");
    run(0, 32'hFFFF_FFFF, 32'h10,        2'b01, 32'h0FFF_FFFF, 35, "divu");
    run(0, 32'hFFFF_FFFF, 32'h10,        2'b11, 32'h0000_000F, 35, "remu");
    run(0, 32'h5,         32'h0,         2'b00, 32'hFFFF_FFFF, 2,  "div 5/0 eo");
    run(1, 32'h5,         32'h0,         2'b00, 32'hFFFF_FFFF, 35, "div 5/0 noeo");
    run(1, 32'hFFFF_FFFB, 32'h0,         2'b00, 32'hFFFF_FFFF, 35, "div -5/0 noeo");
    run(0, 32'h5,         32'h0,         2'b11, 32'h5,         2,  "remu 5/0");
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'h8000_0000, 2,  "div ovf");
    run(0, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0,         2,  "rem ovf");
    run(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h0,         35, "rem ovf noeo");
    run(0, 32'hFFFF_FFF8, 32'h3,         2'b10, 32'hFFFF_FFFE, 35, "rem -8/3");
    run(2, 32'd100,       32'd7,         2'b00, 32'd14,        11, "div 100/7 r4");

    // Kill at t+10, then a fresh op completes normally.
    launch(0, 32'd1000, 32'd7, 2'b00, 6'd40);
    tick(9);
    check("busy before kill", 32'(busy[0]), 32'h1);
    kill[0] = 1'b1;
    tick(1);
    kill[0] = 1'b0;
    check("busy after kill", 32'(busy[0]), 32'h0);
    check("done after kill", 32'(done[0]), 32'h0);
    run(0, 32'd1000, 32'd7, 2'b00, 32'd142, 35, "after kill");

    start[0] = 1'b1; kill[0] = 1'b1; op1[0] = 32'd9; op2[0] = 32'd3;
    tick(1);
    start[0] = 1'b0; kill[0] = 1'b0;
    check("kill+start dropped", 32'(busy[0]), 32'h0);
    tick(40);

    // Held result, ignored starts, then back-to-back pop+start.
    launch(2, 32'd100, 32'd7, 2'b00, 6'd50);
    wait_done(2, 32'd14, 11, 6'd50, "hold first");
    repeat (5) begin
      start[2] = 1'b1; op1[2] = $urandom; op2[2] = $urandom;
      tick(1);
      check("held result", res[2], 32'd14);
      check("held done", 32'(done[2]), 32'h1);
    end
    pop[2] = 1'b1; start[2] = 1'b1; op1[2] = 32'd9; op2[2] = 32'd3;
    cmd[2] = 2'b00; dest[2] = 6'd51;
    tick(1);
    pop[2] = 1'b0; start[2] = 1'b0;
    check("b2b no bubble busy", 32'(busy[2]), 32'h1);
    check("b2b done low", 32'(done[2]), 32'h0);
    wait_done(2, 32'd3, 11, 6'd51, "b2b 9/3");
    pop_it(2);

    // Async reset mid-iteration.
    launch(0, 32'd12345, 32'd11, 2'b01, 6'd60);
    tick(5);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst busy", 32'(busy[k]), 32'h0);
      check("rst done", 32'(done[k]), 32'h0);
      check("rst res", res[k], 32'h0);
      check("rst dest", 32'(dst[k]), 32'h0);
    end
    @(negedge clk);
    #1 reset = 1'b0;
    tick(1);

    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        start[k] = $urandom_range(0, 3) != 0;
        kill[k]  = $urandom_range(0, 49) == 0;
        pop[k]   = $urandom_range(0, 2) != 0;
        op1[k]   = pick();
        op2[k]   = pick();
        cmd[k]   = 2'($urandom);
        dest[k]  = 6'($urandom);
      end
      tick(1);
    end
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; kill[k] = 1'b0; pop[k] = 1'b0;
    end
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
